debug_write_arbiter: RTL and testbench

//  Shares the single simulation debug write port (en/we/addr/data sink) among N_REQ requesters
//  (cores, DMA, monitors). Per-requester FIFOs; round-robin grant; multi-word records (e.g. SAFE

---
 rtl/debug_write_arbiter_pkg.sv | 52 +++++
 rtl/debug_write_arbiter_fifo.sv | 56 +++++
 rtl/debug_write_arbiter.sv | 151 +++++++++++++++
 tb/tb_debug_write_arbiter.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_write_arbiter_pkg.sv
// Shared types and constants for the debug write arbiter: the queued write record,
// the debug address map and the arbitration state encoding.
package DebugArbPkg;

   localparam int DBG_ADDR_W = 24;
   localparam int DBG_DATA_W = 32;

   typedef struct packed {
      logic [DBG_ADDR_W-1:0] addr;
      logic [DBG_DATA_W-1:0] data;
      logic                  last;
   } dbg_wr_t;

   localparam logic [DBG_ADDR_W-1:0] DBG_UART    = 24'h00;
   localparam logic [DBG_ADDR_W-1:0] DBG_HALT    = 24'h04;
   localparam logic [DBG_ADDR_W-1:0] DBG_TRAFFIC = 24'h08;
   localparam logic [DBG_ADDR_W-1:0] DBG_SCHED   = 24'h10;

   localparam logic [DBG_ADDR_W-1:0] DBG_PIPE_0  = 24'h20;
   localparam logic [DBG_ADDR_W-1:0] DBG_PIPE_1  = 24'h24;
   localparam logic [DBG_ADDR_W-1:0] DBG_PIPE_2  = 24'h28;
   localparam logic [DBG_ADDR_W-1:0] DBG_PIPE_3  = 24'h2C;
   localparam logic [DBG_ADDR_W-1:0] DBG_PIPE_4  = 24'h30;
   localparam logic [DBG_ADDR_W-1:0] DBG_PIPE_5  = 24'h34;
   localparam logic [DBG_ADDR_W-1:0] DBG_PIPE_6  = 24'h38;
   localparam logic [DBG_ADDR_W-1:0] DBG_PIPE_7  = 24'h3C;
   localparam logic [DBG_ADDR_W-1:0] DBG_PIPE_8  = 24'h40;
   localparam logic [DBG_ADDR_W-1:0] DBG_PIPE_9  = 24'h44;

   // SAFE record: six words, only the final one (0x64) carries last=1.
   localparam logic [DBG_ADDR_W-1:0] DBG_SAFE_0  = 24'h50;
   localparam logic [DBG_ADDR_W-1:0] DBG_SAFE_1  = 24'h54;
   localparam logic [DBG_ADDR_W-1:0] DBG_SAFE_2  = 24'h58;
   localparam logic [DBG_ADDR_W-1:0] DBG_SAFE_3  = 24'h5C;
   localparam logic [DBG_ADDR_W-1:0] DBG_SAFE_4  = 24'h60;
   localparam logic [DBG_ADDR_W-1:0] DBG_SAFE_5  = 24'h64;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   // (base + off) mod n, valid for base < n and off <= n.
   function automatic int unsigned wrap_add(input int unsigned base,
                                            input int unsigned off,
                                            input int unsigned n);
      int unsigned s;
      s = base + off;
      return (s >= n) ? (s - n) : s;
   endfunction

endpackage

// File: rtl/debug_write_arbiter_fifo.sv
// Per-requester synchronous FIFO of debug write records; flags come from the
// registered occupancy only, so full/empty never depend on this cycle's pop.
module debug_arb_fifo
   import DebugArbPkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    clk_i,
   input  logic    rst_ni,
   input  logic    push_i,
   input  dbg_wr_t wdata_i,
   input  logic    pop_i,
   output dbg_wr_t rdata_o,
   output logic    full_o,
   output logic    empty_o
);

   localparam int AW      = $clog2(DEPTH);
   localparam int COUNT_W = AW + 1;

   dbg_wr_t              mem_q [DEPTH];
   logic [AW-1:0]        wr_ptr_q;
   logic [AW-1:0]        rd_ptr_q;
   logic [COUNT_W-1:0]   count_q;
   logic                 do_push;
   logic                 do_pop;

   assign full_o  = (count_q == COUNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign rdata_o = mem_q[rd_ptr_q];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + COUNT_W'(1);
            2'b01:   count_q <= count_q - COUNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; entries are only read below count_q,
   // so clearing the pointers and count is enough to flush the FIFO.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/debug_write_arbiter.sv
// Round-robin arbiter sharing the debug write port among N_REQ requesters, with
// multi-word record locking. Optional stall counters under DBG_ARB_STATS_EN.
module debug_write_arbiter
   import DebugArbPkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic [N_REQ-1:0]                     req_valid_i,
   output logic [N_REQ-1:0]                     req_ready_o,
   input  logic [N_REQ-1:0][DBG_ADDR_W-1:0]     req_addr_i,
   input  logic [N_REQ-1:0][DBG_DATA_W-1:0]     req_data_i,
   input  logic [N_REQ-1:0]                     req_last_i,
   output logic                                 dbg_en_o,
   output logic                                 dbg_we_o,
   output logic [DBG_ADDR_W-1:0]                dbg_addr_o,
   output logic [DBG_DATA_W-1:0]                dbg_data_o
`ifdef DBG_ARB_STATS_EN
   ,
   output logic [N_REQ-1:0][31:0]               stall_cnt_o
`endif
);

   localparam int IDX_W = $clog2(N_REQ);

   logic [N_REQ-1:0] full;
   logic [N_REQ-1:0] empty;
   logic [N_REQ-1:0] push;
   logic [N_REQ-1:0] pop;
   dbg_wr_t          head [N_REQ];

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [IDX_W-1:0] rr_q, rr_d;
   logic             dbg_en_q;
   logic [DBG_ADDR_W-1:0] dbg_addr_q;
   logic [DBG_DATA_W-1:0] dbg_data_q;

   logic             sel_valid;
   logic [IDX_W-1:0] sel_idx;
   logic [IDX_W-1:0] cand;
   dbg_wr_t          sel_word;

   for (genvar g = 0; g < N_REQ; g++) begin : g_fifo
      dbg_wr_t wr_word;
      assign wr_word = '{addr: req_addr_i[g], data: req_data_i[g], last: req_last_i[g]};
      assign push[g] = req_valid_i[g] & ~full[g];

      debug_arb_fifo #(
         .DEPTH(FIFO_DEPTH)
      ) u_fifo (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .push_i  (push[g]),
         .wdata_i (wr_word),
         .pop_i   (pop[g]),
         .rdata_o (head[g]),
         .full_o  (full[g]),
         .empty_o (empty[g])
      );
   end

   assign req_ready_o = ~full;

   // NOTE: every output of a combinational block gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      sel_valid = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      if (state_q == ARB_LOCKED) begin
         sel_valid = ~empty[owner_q];
         sel_idx   = owner_q;
      end else begin
         // Scan downward so the candidate nearest the rr pointer is the last one written.
         for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'(wrap_add(32'(rr_q), 32'(k), 32'(N_REQ)));
            if (!empty[cand]) begin
               sel_valid = 1'b1;
               sel_idx   = cand;
            end
         end
      end
      sel_word = head[sel_idx];
   end

   assign pop = sel_valid ? (N_REQ'(1) << sel_idx) : '0;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      if (sel_valid) begin
         if (sel_word.last) begin
            state_d = ARB_IDLE;
            rr_d    = IDX_W'(wrap_add(32'(sel_idx), 32'd1, 32'(N_REQ)));
         end else begin
            state_d = ARB_LOCKED;
            owner_d = sel_idx;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ARB_IDLE;
         owner_q    <= '0;
         rr_q       <= '0;
         dbg_en_q   <= 1'b0;
         dbg_addr_q <= '0;
         dbg_data_q <= '0;
      end else begin
         // NOTE: non-blocking assignments make every register sample pre-edge values,
         // independent of statement order.
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_q     <= rr_d;
         dbg_en_q <= sel_valid;
         if (sel_valid) begin
            dbg_addr_q <= sel_word.addr;
            dbg_data_q <= sel_word.data;
         end
      end
   end

   assign dbg_en_o   = dbg_en_q;
   assign dbg_we_o   = dbg_en_q;
   assign dbg_addr_o = dbg_addr_q;
   assign dbg_data_o = dbg_data_q;

`ifdef DBG_ARB_STATS_EN
   logic [N_REQ-1:0][31:0] stall_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_q <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (req_valid_i[i] && full[i] && (stall_q[i] != 32'hFFFF_FFFF)) begin
               stall_q[i] <= stall_q[i] + 32'd1;
            end
         end
      end
   end

   assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_debug_write_arbiter.sv
// Self-checking bench for debug_write_arbiter: directed scenarios plus randomized
// traffic against a queue-level model of the arbitration rules.
module tb_debug_write_arbiter;
   import DebugArbPkg::*;

   localparam int N     = 4;
   localparam int DEPTH = 4;

   logic                        clk_i = 1'b0;
   logic                        rst_ni;
   logic [N-1:0]                req_valid_i;
   logic [N-1:0]                req_ready_o;
   logic [N-1:0][23:0]          req_addr_i;
   logic [N-1:0][31:0]          req_data_i;
   logic [N-1:0]                req_last_i;
   logic                        dbg_en_o;
   logic                        dbg_we_o;
   logic [23:0]                 dbg_addr_o;
   logic [31:0]                 dbg_data_o;
`ifdef DBG_ARB_STATS_EN
   logic [N-1:0][31:0]          stall_cnt_o;
`endif

   debug_write_arbiter #(
      .N_REQ      (N),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_addr_i  (req_addr_i),
      .req_data_i  (req_data_i),
      .req_last_i  (req_last_i),
      .dbg_en_o    (dbg_en_o),
      .dbg_we_o    (dbg_we_o),
      .dbg_addr_o  (dbg_addr_o),
      .dbg_data_o  (dbg_data_o)
`ifdef DBG_ARB_STATS_EN
      ,
      .stall_cnt_o (stall_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int          cyc;
      logic [23:0] addr;
      logic [31:0] data;
   } obs_t;

   // Stimulus queues (words not yet offered/accepted) and model FIFOs.
   dbg_wr_t src [N][$];
   dbg_wr_t mq  [N][$];
   bit      gate [N];
   bit      m_locked;
   int      m_owner;
   int      m_rr;
   int      m_stall [N];
   logic          exp_en;
   logic [23:0]   exp_addr;
   logic [31:0]   exp_data;
   logic [N-1:0]  exp_ready;
   obs_t    obs [$];
   int      cyc;
   int      n_assert;
   int      n_fail;

   function automatic dbg_wr_t mk(input logic [23:0] a, input logic [31:0] d, input logic l);
      dbg_wr_t w;
      w.addr = a;
      w.data = d;
      w.last = l;
      return w;
   endfunction

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (src[i].size() > 0 && gate[i]) begin
            req_valid_i[i] = 1'b1;
            req_addr_i[i]  = src[i][0].addr;
            req_data_i[i]  = src[i][0].data;
            req_last_i[i]  = src[i][0].last;
         end else begin
            req_valid_i[i] = 1'b0;
            req_addr_i[i]  = '0;
            req_data_i[i]  = '0;
            req_last_i[i]  = 1'b0;
         end
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < N; i++) begin
         mq[i].delete();
         src[i].delete();
         m_stall[i] = 0;
         gate[i]    = 1'b1;
      end
      m_locked  = 1'b0;
      m_owner   = 0;
      m_rr      = 0;
      exp_en    = 1'b0;
      exp_addr  = '0;
      exp_data  = '0;
      exp_ready = '1;
   endtask

   // One clock: apply the arbitration rules to the model at the edge, then sample the DUT.
   task automatic tick();
      bit      acc [N];
      bit      popped;
      int      win;
      dbg_wr_t w;
      obs_t    o;
      @(posedge clk_i);
      cyc++;
      popped = 1'b0;
      win    = 0;
      w      = mk('0, '0, 1'b0);
      for (int i = 0; i < N; i++) begin
         acc[i] = req_valid_i[i] && (mq[i].size() < DEPTH);
         if (req_valid_i[i] && !acc[i]) m_stall[i]++;
      end
      if (m_locked) begin
         if (mq[m_owner].size() > 0) begin
            w = mq[m_owner].pop_front();
            popped = 1'b1;
            win = m_owner;
         end
      end else begin
         for (int k = 0; k < N && !popped; k++) begin
            int c;
            c = (m_rr + k) % N;
            if (mq[c].size() > 0) begin
               w = mq[c].pop_front();
               popped = 1'b1;
               win = c;
            end
         end
      end
      exp_en = popped;
      if (popped) begin
         exp_addr = w.addr;
         exp_data = w.data;
         if (w.last) begin
            m_locked = 1'b0;
            m_rr     = (win + 1) % N;
         end else begin
            m_locked = 1'b1;
            m_owner  = win;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (acc[i]) mq[i].push_back(src[i].pop_front());
         exp_ready[i] = (mq[i].size() < DEPTH);
      end
      #1;
      if (dbg_en_o) begin
         o.cyc  = cyc;
         o.addr = dbg_addr_o;
         o.data = dbg_data_o;
         obs.push_back(o);
      end
      drive();
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      model_clear();
      drive();
      @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      model_clear();
      drive();
      repeat (2) @(posedge clk_i);
      #1;
      n_assert++;
      if (dbg_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %0b need 0", dbg_en_o); end
      n_assert++;
      if (dbg_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0b need 0", dbg_we_o); end
      n_assert++;
      if (dbg_addr_o !== 24'h0 || dbg_data_o !== 32'h0) begin
         n_fail++; $display("FAIL reset_bus: got addr %h data %h need 0/0", dbg_addr_o, dbg_data_o);
      end
      n_assert++;
      if (req_ready_o !== 4'hF) begin n_fail++; $display("FAIL reset_ready: got %b need 1111", req_ready_o); end
`ifdef DBG_ARB_STATS_EN
      for (int i = 0; i < N; i++) begin
         n_assert++;
         if (stall_cnt_o[i] !== 32'h0) begin
            n_fail++; $display("FAIL reset_stall[%0d]: got %0d need 0", i, stall_cnt_o[i]);
         end
      end
`endif
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   task automatic test_single_word();
      obs.delete();
      src[0].push_back(mk(DBG_UART, 32'h41, 1'b1));
      drive();
      tick();
      n_assert++;
      if (dbg_en_o !== 1'b0) begin n_fail++; $display("FAIL single_early: got en %0b need 0", dbg_en_o); end
      tick();
      n_assert++;
      if (dbg_en_o !== 1'b1 || dbg_we_o !== 1'b1 || dbg_addr_o !== 24'h0 || dbg_data_o !== 32'h41) begin
         n_fail++;
         $display("FAIL single_issue: got en %0b we %0b addr %h data %h need 1 1 000000 00000041",
                  dbg_en_o, dbg_we_o, dbg_addr_o, dbg_data_o);
      end
      tick();
      n_assert++;
      if (dbg_en_o !== 1'b0 || dbg_data_o !== 32'h41) begin
         n_fail++; $display("FAIL single_after: got en %0b data %h need 0 / held 00000041", dbg_en_o, dbg_data_o);
      end
   endtask

   task automatic test_round_robin();
      int start;
      do_reset();
      for (int r = 0; r < 2; r++) begin
         obs.delete();
         for (int i = 0; i < N; i++) src[i].push_back(mk(DBG_TRAFFIC, 32'(32'hA000_0000 | (r << 8) | i), 1'b1));
         drive();
         tick();
         start = cyc;
         repeat (5) tick();
         n_assert++;
         if (obs.size() != 4) begin n_fail++; $display("FAIL rr_count round %0d: got %0d words need 4", r, obs.size()); end
         for (int j = 0; j < 4 && j < obs.size(); j++) begin
            n_assert++;
            if (obs[j].data !== 32'(32'hA000_0000 | (r << 8) | j) || obs[j].cyc != start + 1 + j) begin
               n_fail++;
               $display("FAIL rr_order round %0d slot %0d: got data %h cyc %0d need %h cyc %0d",
                        r, j, obs[j].data, obs[j].cyc, 32'(32'hA000_0000 | (r << 8) | j), start + 1 + j);
            end
         end
      end
   endtask

   task automatic test_lock();
      obs.delete();
      for (int j = 0; j < 6; j++) src[1].push_back(mk(DBG_SAFE_0 + 24'(4 * j), 32'(32'hB100_0000 | j), j == 5));
      drive();
      tick();
      tick();
      src[2].push_back(mk(DBG_TRAFFIC, 32'hB200_0000, 1'b1));
      drive();
      repeat (12) tick();
      n_assert++;
      if (obs.size() != 7) begin n_fail++; $display("FAIL lock_count: got %0d words need 7", obs.size()); end
      for (int j = 0; j < 7 && j < obs.size(); j++) begin
         logic [23:0] ea;
         logic [31:0] ed;
         ea = (j < 6) ? DBG_SAFE_0 + 24'(4 * j) : DBG_TRAFFIC;
         ed = (j < 6) ? 32'(32'hB100_0000 | j) : 32'hB200_0000;
         n_assert++;
         if (obs[j].addr !== ea || obs[j].data !== ed || obs[j].cyc != obs[0].cyc + j) begin
            n_fail++;
            $display("FAIL lock_seq slot %0d: got addr %h data %h cyc %0d need addr %h data %h cyc %0d",
                     j, obs[j].addr, obs[j].data, obs[j].cyc, ea, ed, obs[0].cyc + j);
         end
      end
   endtask

   task automatic test_lock_gap();
      logic [23:0] ea [4];
      obs.delete();
      src[0].push_back(mk(DBG_SAFE_0, 32'hC000_0050, 1'b0));
      src[0].push_back(mk(DBG_SAFE_1, 32'hC000_0054, 1'b0));
      drive();
      tick();
      src[3].push_back(mk(DBG_HALT, 32'hC300_0004, 1'b1));
      drive();
      tick();
      tick();
      for (int g = 0; g < 5; g++) begin
         tick();
         n_assert++;
         if (dbg_en_o !== 1'b0) begin n_fail++; $display("FAIL gap_idle cycle %0d: got en %0b need 0", g, dbg_en_o); end
      end
      src[0].push_back(mk(DBG_SAFE_2, 32'hC000_0058, 1'b1));
      drive();
      repeat (4) tick();
      ea[0] = DBG_SAFE_0; ea[1] = DBG_SAFE_1; ea[2] = DBG_SAFE_2; ea[3] = DBG_HALT;
      n_assert++;
      if (obs.size() != 4) begin n_fail++; $display("FAIL gap_count: got %0d words need 4", obs.size()); end
      for (int j = 0; j < 4 && j < obs.size(); j++) begin
         n_assert++;
         if (obs[j].addr !== ea[j]) begin
            n_fail++; $display("FAIL gap_order slot %0d: got addr %h need %h", j, obs[j].addr, ea[j]);
         end
      end
      if (obs.size() == 4) begin
         n_assert++;
         if (obs[2].cyc != obs[1].cyc + 7 || obs[3].cyc != obs[2].cyc + 1) begin
            n_fail++;
            $display("FAIL gap_timing: got cyc %0d %0d %0d need %0d %0d %0d", obs[1].cyc, obs[2].cyc, obs[3].cyc,
                     obs[1].cyc, obs[1].cyc + 7, obs[1].cyc + 8);
         end
      end
   endtask

   task automatic test_full();
      obs.delete();
      src[0].push_back(mk(DBG_SAFE_0, 32'hD000_0050, 1'b0));
      drive();
      tick();
      tick();
      for (int j = 0; j < DEPTH + 2; j++) src[2].push_back(mk(DBG_PIPE_0 + 24'(4 * j), 32'(32'hD200_0000 | j), 1'b1));
      drive();
      for (int c = 0; c < 8; c++) begin
         tick();
         n_assert++;
         if (req_ready_o !== exp_ready) begin
            n_fail++; $display("FAIL full_ready cycle %0d: got %b need %b", c, req_ready_o, exp_ready);
         end
      end
      n_assert++;
      if (req_ready_o[2] !== 1'b0) begin n_fail++; $display("FAIL full_stuck: got ready[2] %0b need 0", req_ready_o[2]); end
`ifdef DBG_ARB_STATS_EN
      n_assert++;
      if (stall_cnt_o[2] !== 32'(m_stall[2])) begin
         n_fail++; $display("FAIL full_stall: got %0d need %0d", stall_cnt_o[2], m_stall[2]);
      end
`endif
      src[0].push_back(mk(DBG_SAFE_5, 32'hD000_0064, 1'b1));
      drive();
      repeat (12) tick();
      n_assert++;
      if (obs.size() != DEPTH + 4) begin n_fail++; $display("FAIL full_count: got %0d words need %0d", obs.size(), DEPTH + 4); end
      for (int j = 0; j < DEPTH + 4 && j < obs.size(); j++) begin
         logic [31:0] ed;
         ed = (j == 0) ? 32'hD000_0050 : (j == 1) ? 32'hD000_0064 : 32'(32'hD200_0000 | (j - 2));
         n_assert++;
         if (obs[j].data !== ed) begin
            n_fail++; $display("FAIL full_seq slot %0d: got data %h need %h", j, obs[j].data, ed);
         end
      end
      n_assert++;
      if (req_ready_o !== 4'hF) begin n_fail++; $display("FAIL full_drained: got ready %b need 1111", req_ready_o); end
   endtask

   task automatic test_reset_mid_record();
      obs.delete();
      src[1].push_back(mk(DBG_SAFE_0, 32'hE100_0050, 1'b0));
      src[1].push_back(mk(DBG_SAFE_1, 32'hE100_0054, 1'b0));
      src[1].push_back(mk(DBG_SAFE_2, 32'hE100_0058, 1'b0));
      drive();
      tick();
      src[3].push_back(mk(DBG_TRAFFIC, 32'hE300_0008, 1'b1));
      drive();
      tick();
      tick();
      #2;
      rst_ni = 1'b0;
      #1;
      n_assert++;
      if (dbg_en_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_en: got %0b need 0", dbg_en_o); end
      n_assert++;
      if (req_ready_o !== 4'hF) begin n_fail++; $display("FAIL rstmid_ready: got %b need 1111", req_ready_o); end
      model_clear();
      drive();
      @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      obs.delete();
      src[3].push_back(mk(DBG_TRAFFIC, 32'hE300_1111, 1'b1));
      src[1].push_back(mk(DBG_UART, 32'hE100_1111, 1'b1));
      drive();
      tick();
      n_assert++;
      if (dbg_en_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_latency: got en %0b need 0", dbg_en_o); end
      tick();
      n_assert++;
      if (dbg_en_o !== 1'b1 || dbg_data_o !== 32'hE100_1111) begin
         n_fail++; $display("FAIL rstmid_first: got en %0b data %h need 1 e1001111", dbg_en_o, dbg_data_o);
      end
      tick();
      n_assert++;
      if (dbg_en_o !== 1'b1 || dbg_data_o !== 32'hE300_1111) begin
         n_fail++; $display("FAIL rstmid_second: got en %0b data %h need 1 e3001111", dbg_en_o, dbg_data_o);
      end
      repeat (2) tick();
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 700; c++) begin
         for (int i = 0; i < N; i++) begin
            if (c < 640 && src[i].size() < 3 && $urandom_range(0, 2) == 0) begin
               int len;
               len = int'($urandom_range(1, 3));
               for (int j = 0; j < len; j++) begin
                  src[i].push_back(mk(24'($urandom_range(0, 25) * 4), {4'(i), 28'($urandom)}, j == len - 1));
               end
            end
            gate[i] = (c >= 640) || ($urandom_range(0, 3) != 0);
         end
         drive();
         tick();
         n_assert++;
         if (dbg_en_o !== exp_en) begin
            n_fail++; $display("FAIL rand_en cyc %0d: got %0b need %0b", cyc, dbg_en_o, exp_en);
         end
         if (exp_en) begin
            n_assert++;
            if (dbg_addr_o !== exp_addr || dbg_data_o !== exp_data) begin
               n_fail++;
               $display("FAIL rand_word cyc %0d: got addr %h data %h need addr %h data %h",
                        cyc, dbg_addr_o, dbg_data_o, exp_addr, exp_data);
            end
         end
         n_assert++;
         if (req_ready_o !== exp_ready) begin
            n_fail++; $display("FAIL rand_ready cyc %0d: got %b need %b", cyc, req_ready_o, exp_ready);
         end
`ifdef DBG_ARB_STATS_EN
         for (int i = 0; i < N; i++) begin
            n_assert++;
            if (stall_cnt_o[i] !== 32'(m_stall[i])) begin
               n_fail++; $display("FAIL rand_stall[%0d] cyc %0d: got %0d need %0d", i, cyc, stall_cnt_o[i], m_stall[i]);
            end
         end
`endif
      end
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      cyc      = 0;
      rst_ni   = 1'b0;
      test_reset();
      test_single_word();
      test_round_robin();
      test_lock();
      test_lock_gap();
      test_full();
      test_reset_mid_record();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within 200000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
